// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the ROM download loader.
package rom_loader_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    localparam int MAX_REGIONS = 32;

    localparam logic [24:0] DEFAULT_REGION_END [8] = '{
        25'h10000, 25'h20000, 25'h30000, 25'h40000,
        25'h60000, 25'h80000, 25'hC0000, 25'hE0000
    };

endpackage

// File: rtl/rom_region_decode.sv
// Combinational region decode: lowest region whose exclusive end lies above addr wins.
module rom_region_decode
    import rom_loader_pkg::*;
#(
    parameter int          NUM_REGIONS = 8,
    parameter logic [24:0] REGION_END [NUM_REGIONS] = DEFAULT_REGION_END
) (
    input  logic [24:0]            addr,
    output logic [NUM_REGIONS-1:0] sel,
    output logic [24:0]            start,
    output logic                   out_of_range
);

    always_comb begin
        sel          = '0;
        start        = '0;
        out_of_range = 1'b1;
        // Walk downwards so the lowest matching index is the last one written.
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (addr < REGION_END[i]) begin
                sel          = '0;
                sel[i]       = 1'b1;
                start        = (i == 0) ? 25'h0 : REGION_END[(i == 0) ? 0 : i - 1];
                out_of_range = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rom_loader.sv
// Packs a byte-wide download stream into region-addressed words for a target memory.
// Optional byte checksum enabled by defining ROM_LOADER_CHECKSUM_EN.
//
//   state   | meaning
//   IDLE    | no download in progress
//   COLLECT | assembling bytes into the word accumulator
//   WRITE   | word presented on wr_*, waiting for wr_ack
//   DRAIN   | download ended, final partial word (if any) waiting for wr_ack
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int          NUM_REGIONS = 8,
    parameter int          WORD_BYTES  = 2,
    parameter logic [24:0] REGION_END [NUM_REGIONS] = DEFAULT_REGION_END
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    ioctl_download,
    input  logic                    ioctl_wr,
    input  logic [24:0]             ioctl_addr,
    input  logic [7:0]              ioctl_dout,
    output logic                    ioctl_wait,
    output logic                    wr_req,
    input  logic                    wr_ack,
    output logic [NUM_REGIONS-1:0]  wr_cs,
    output logic [23:0]             wr_addr,
    output logic [8*WORD_BYTES-1:0] wr_data,
    output logic [WORD_BYTES-1:0]   wr_be,
    output logic                    load_done,
    output logic                    bad_addr,
    output logic [15:0]             checksum
);

    state_t                  state, state_nxt;
    logic                    dl_q;
    logic [8*WORD_BYTES-1:0] acc_data, acc_data_nxt;
    logic [WORD_BYTES-1:0]   acc_be, acc_be_nxt;
    logic [NUM_REGIONS-1:0]  acc_cs, acc_cs_nxt;
    logic [23:0]             acc_addr, acc_addr_nxt;
    logic                    hold_valid, hold_valid_nxt;
    logic [24:0]             hold_addr, hold_addr_nxt;
    logic [7:0]              hold_data, hold_data_nxt;
    logic                    req_nxt, done_nxt, bad_nxt;
    logic [NUM_REGIONS-1:0]  cs_nxt;
    logic [23:0]             addr_nxt;
    logic [8*WORD_BYTES-1:0] data_nxt;
    logic [WORD_BYTES-1:0]   be_nxt;
    logic                    sum_add, sum_clr;

    logic                    dl_rise, byte_in, acc_valid, same_word;
    logic [24:0]             proc_addr, reg_start, offset, lane_idx;
    logic [7:0]              proc_data;
    logic [23:0]             word_idx;
    logic [NUM_REGIONS-1:0]  reg_sel;
    logic                    reg_oor;
    logic [8*WORD_BYTES-1:0] lane_bytes, merged_data;
    logic [WORD_BYTES-1:0]   lane_be, merged_be;

    assign dl_rise    = ioctl_download && !dl_q;
    assign byte_in    = ioctl_download && ioctl_wr;
    assign acc_valid  = |acc_be;
    assign ioctl_wait = wr_req || hold_valid;

    // A held byte always takes precedence over the live stream.
    assign proc_addr = hold_valid ? hold_addr : ioctl_addr;
    assign proc_data = hold_valid ? hold_data : ioctl_dout;

    rom_region_decode #(
        .NUM_REGIONS (NUM_REGIONS),
        .REGION_END  (REGION_END)
    ) u_decode (
        .addr         (proc_addr),
        .sel          (reg_sel),
        .start        (reg_start),
        .out_of_range (reg_oor)
    );

    assign offset    = proc_addr - reg_start;
    assign word_idx  = 24'(offset / 25'(WORD_BYTES));
    assign lane_idx  = offset % 25'(WORD_BYTES);
    assign same_word = acc_valid && (acc_cs == reg_sel) && (acc_addr == word_idx);

    always_comb begin
        lane_be    = '0;
        lane_bytes = '0;
        for (int b = 0; b < WORD_BYTES; b++) begin
            if (lane_idx == 25'(b)) begin
                lane_be[b]           = 1'b1;
                lane_bytes[8*b +: 8] = proc_data;
            end
        end
    end

    assign merged_data = (same_word ? acc_data : '0) | lane_bytes;
    assign merged_be   = (same_word ? acc_be   : '0) | lane_be;

    always_comb begin
        state_nxt      = state;
        acc_data_nxt   = acc_data;
        acc_be_nxt     = acc_be;
        acc_cs_nxt     = acc_cs;
        acc_addr_nxt   = acc_addr;
        hold_valid_nxt = hold_valid;
        hold_addr_nxt  = hold_addr;
        hold_data_nxt  = hold_data;
        req_nxt        = wr_req;
        cs_nxt         = wr_cs;
        addr_nxt       = wr_addr;
        data_nxt       = wr_data;
        be_nxt         = wr_be;
        done_nxt       = load_done;
        bad_nxt        = bad_addr;
        sum_add        = 1'b0;
        sum_clr        = 1'b0;

        if (dl_rise) begin
            state_nxt      = COLLECT;
            acc_be_nxt     = '0;
            acc_data_nxt   = '0;
            hold_valid_nxt = 1'b0;
            req_nxt        = 1'b0;
            done_nxt       = 1'b0;
            bad_nxt        = 1'b0;
            sum_clr        = 1'b1;
        end else begin
            case (state)
                COLLECT: begin
                    if (acc_valid && acc_be[WORD_BYTES-1]) begin
                        // Word completed by the byte that displaced the previous partial word.
                        req_nxt   = 1'b1;
                        cs_nxt    = acc_cs;
                        addr_nxt  = acc_addr;
                        data_nxt  = acc_data;
                        be_nxt    = acc_be;
                        acc_be_nxt   = '0;
                        acc_data_nxt = '0;
                        state_nxt = WRITE;
                        if (byte_in) begin
                            if (hold_valid) begin
                                bad_nxt = 1'b1;
                            end else begin
                                hold_valid_nxt = 1'b1;
                                hold_addr_nxt  = ioctl_addr;
                                hold_data_nxt  = ioctl_dout;
                            end
                        end
                    end else if (hold_valid || byte_in) begin
                        if (hold_valid) begin
                            hold_valid_nxt = byte_in;
                            hold_addr_nxt  = ioctl_addr;
                            hold_data_nxt  = ioctl_dout;
                        end
                        if (reg_oor) begin
                            bad_nxt = 1'b1;
                        end else begin
                            sum_add = 1'b1;
                            if (acc_valid && !same_word) begin
                                req_nxt      = 1'b1;
                                cs_nxt       = acc_cs;
                                addr_nxt     = acc_addr;
                                data_nxt     = acc_data;
                                be_nxt       = acc_be;
                                acc_data_nxt = lane_bytes;
                                acc_be_nxt   = lane_be;
                                acc_cs_nxt   = reg_sel;
                                acc_addr_nxt = word_idx;
                                state_nxt    = WRITE;
                            end else if (lane_be[WORD_BYTES-1]) begin
                                req_nxt      = 1'b1;
                                cs_nxt       = reg_sel;
                                addr_nxt     = word_idx;
                                data_nxt     = merged_data;
                                be_nxt       = merged_be;
                                acc_be_nxt   = '0;
                                acc_data_nxt = '0;
                                state_nxt    = WRITE;
                            end else begin
                                acc_data_nxt = merged_data;
                                acc_be_nxt   = merged_be;
                                acc_cs_nxt   = reg_sel;
                                acc_addr_nxt = word_idx;
                            end
                        end
                    end else if (!ioctl_download) begin
                        if (acc_valid) begin
                            req_nxt      = 1'b1;
                            cs_nxt       = acc_cs;
                            addr_nxt     = acc_addr;
                            data_nxt     = acc_data;
                            be_nxt       = acc_be;
                            acc_be_nxt   = '0;
                            acc_data_nxt = '0;
                        end
                        state_nxt = DRAIN;
                    end
                end
                WRITE: begin
                    if (byte_in) begin
                        if (hold_valid) begin
                            bad_nxt = 1'b1;
                        end else begin
                            hold_valid_nxt = 1'b1;
                            hold_addr_nxt  = ioctl_addr;
                            hold_data_nxt  = ioctl_dout;
                        end
                    end
                    if (wr_ack) begin
                        req_nxt   = 1'b0;
                        state_nxt = COLLECT;
                    end
                end
                DRAIN: begin
                    if (!wr_req || wr_ack) begin
                        req_nxt   = 1'b0;
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            dl_q       <= 1'b0;
            acc_data   <= '0;
            acc_be     <= '0;
            acc_cs     <= '0;
            acc_addr   <= '0;
            hold_valid <= 1'b0;
            hold_addr  <= '0;
            hold_data  <= '0;
            wr_req     <= 1'b0;
            wr_cs      <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_be      <= '0;
            load_done  <= 1'b0;
            bad_addr   <= 1'b0;
        end else begin
            state      <= state_nxt;
            dl_q       <= ioctl_download;
            acc_data   <= acc_data_nxt;
            acc_be     <= acc_be_nxt;
            acc_cs     <= acc_cs_nxt;
            acc_addr   <= acc_addr_nxt;
            hold_valid <= hold_valid_nxt;
            hold_addr  <= hold_addr_nxt;
            hold_data  <= hold_data_nxt;
            wr_req     <= req_nxt;
            wr_cs      <= cs_nxt;
            wr_addr    <= addr_nxt;
            wr_data    <= data_nxt;
            wr_be      <= be_nxt;
            load_done  <= done_nxt;
            bad_addr   <= bad_nxt;
        end
    end

`ifdef ROM_LOADER_CHECKSUM_EN
    logic [15:0] sum_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     sum_q <= '0;
        else if (sum_clr) sum_q <= '0;
        else if (sum_add) sum_q <= sum_q + 16'(proc_data);
    end

    assign checksum = sum_q;
`else
    logic unused_sum;
    assign unused_sum = sum_add ^ sum_clr;
    assign checksum   = '0;
`endif

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader with default parameters (8 regions, 2-byte words).
module tb_rom_loader;

    localparam int NR = 8;
    localparam int WB = 2;

`ifdef ROM_LOADER_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              ioctl_download = 1'b0;
    logic              ioctl_wr = 1'b0;
    logic [24:0]       ioctl_addr = '0;
    logic [7:0]        ioctl_dout = '0;
    logic              ioctl_wait;
    logic              wr_req;
    logic              wr_ack = 1'b0;
    logic [NR-1:0]     wr_cs;
    logic [23:0]       wr_addr;
    logic [8*WB-1:0]   wr_data;
    logic [WB-1:0]     wr_be;
    logic              load_done;
    logic              bad_addr;
    logic [15:0]       checksum;

    int n_assert = 0;
    int n_fail   = 0;

    rom_loader #(.NUM_REGIONS(NR), .WORD_BYTES(WB)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .wr_req         (wr_req),
        .wr_ack         (wr_ack),
        .wr_cs          (wr_cs),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_be          (wr_be),
        .load_done      (load_done),
        .bad_addr       (bad_addr),
        .checksum       (checksum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ck(input logic [15:0] v);
        return CK_EN ? 32'(v) : 32'h0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic check_write(input string tag, input logic [NR-1:0] cs, input logic [23:0] a,
                               input logic [15:0] d, input logic [1:0] be);
        chk({tag, "_req"},  32'(wr_req), 32'h1);
        chk({tag, "_cs"},   32'(wr_cs), 32'(cs));
        chk({tag, "_addr"}, 32'(wr_addr), 32'(a));
        chk({tag, "_data"}, 32'(wr_data), 32'(d));
        chk({tag, "_be"},   32'(wr_be), 32'(be));
        chk({tag, "_wait"}, 32'(ioctl_wait), 32'h1);
    endtask

    task automatic ack(input string tag);
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        chk({tag, "_req_drop"}, 32'(wr_req), 32'h0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req"},  32'(wr_req), 32'h0);
        chk({tag, "_wait"}, 32'(ioctl_wait), 32'h0);
        chk({tag, "_cs"},   32'(wr_cs), 32'h0);
        chk({tag, "_addr"}, 32'(wr_addr), 32'h0);
        chk({tag, "_data"}, 32'(wr_data), 32'h0);
        chk({tag, "_be"},   32'(wr_be), 32'h0);
        chk({tag, "_done"}, 32'(load_done), 32'h0);
        chk({tag, "_bad"},  32'(bad_addr), 32'h0);
        chk({tag, "_sum"},  32'(checksum), 32'h0);
    endtask

    initial begin
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();

        // Two bytes fill one word in region 0
        ioctl_download = 1'b1;
        tick();
        send(25'h00000, 8'h11);
        chk("a_no_req_half", 32'(wr_req), 32'h0);
        send(25'h00001, 8'h22);
        check_write("a", 8'h01, 24'h0, 16'h2211, 2'b11);
        ack("a");
        chk("a_sum", 32'(checksum), ck(16'h0033));

        // Lone upper-lane byte at the top of region 1, then region 2 starts at word 0
        send(25'h1FFFF, 8'hAB);
        check_write("b1", 8'h02, 24'h7FFF, 16'hAB00, 2'b10);
        ack("b1");
        send(25'h20000, 8'hCD);
        chk("b2_no_req_half", 32'(wr_req), 32'h0);
        send(25'h20001, 8'hEF);
        check_write("b2", 8'h04, 24'h0, 16'hEFCD, 2'b11);
        ack("b2");

        // Slow ack: one byte held, a second one dropped
        send(25'h30000, 8'h01);
        send(25'h30001, 8'h02);
        check_write("c1", 8'h08, 24'h0, 16'h0201, 2'b11);
        send(25'h30002, 8'h03);
        chk("c_wait_held", 32'(ioctl_wait), 32'h1);
        chk("c_bad_before", 32'(bad_addr), 32'h0);
        send(25'h30003, 8'h04);
        chk("c_bad_overflow", 32'(bad_addr), 32'h1);
        repeat (8) tick();
        chk("c_req_stalled", 32'(wr_req), 32'h1);
        chk("c_data_stable", 32'(wr_data), 32'h0201);
        ack("c1");
        chk("c_wait_hold", 32'(ioctl_wait), 32'h1);
        tick();
        chk("c_wait_free", 32'(ioctl_wait), 32'h0);
        chk("c_no_req", 32'(wr_req), 32'h0);
        send(25'h30003, 8'h05);
        check_write("c2", 8'h08, 24'h1, 16'h0503, 2'b11);
        ack("c2");

        // End download with nothing pending, then restart clears the flags
        ioctl_download = 1'b0;
        tick();
        tick();
        chk("d_done", 32'(load_done), 32'h1);
        chk("d_bad_kept", 32'(bad_addr), 32'h1);
        ioctl_download = 1'b1;
        tick();
        chk("d_done_clr", 32'(load_done), 32'h0);
        chk("d_bad_clr", 32'(bad_addr), 32'h0);
        chk("d_sum_clr", 32'(checksum), 32'h0);

        // Out-of-range byte
        send(25'hE0000, 8'h77);
        chk("d_oor_no_req", 32'(wr_req), 32'h0);
        chk("d_oor_bad", 32'(bad_addr), 32'h1);
        tick();
        chk("d_oor_still_no_req", 32'(wr_req), 32'h0);
        chk("d_oor_sum", 32'(checksum), 32'h0);
        ioctl_download = 1'b0;
        tick();
        ioctl_download = 1'b1;
        tick();
        chk("d_bad_clr2", 32'(bad_addr), 32'h0);

        // Three bytes then end of download: partial final word
        send(25'h40000, 8'hA1);
        send(25'h40001, 8'hA2);
        check_write("e1", 8'h10, 24'h0, 16'hA2A1, 2'b11);
        ack("e1");
        send(25'h40002, 8'hA3);
        chk("e_no_req_half", 32'(wr_req), 32'h0);
        chk("e_sum", 32'(checksum), ck(16'h01E6));
        ioctl_download = 1'b0;
        tick();
        check_write("e2", 8'h10, 24'h1, 16'h00A3, 2'b01);
        chk("e_not_done", 32'(load_done), 32'h0);
        ack("e2");
        chk("e_done", 32'(load_done), 32'h1);

        // Checksum wrap, then asynchronous reset in the middle of a write
        ioctl_download = 1'b1;
        tick();
        chk("f_done_clr", 32'(load_done), 32'h0);
        send(25'h50000, 8'hFF);
        send(25'h50001, 8'hFF);
        check_write("f1", 8'h10, 24'h8000, 16'hFFFF, 2'b11);
        ack("f1");
        send(25'h50002, 8'h02);
        chk("f_sum", 32'(checksum), ck(16'h0200));
        send(25'h50003, 8'h03);
        check_write("f2", 8'h10, 24'h8001, 16'h0302, 2'b11);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("f_rst");
        tick();
        reset_n = 1'b1;
        tick();
        chk("f_after_rst_req", 32'(wr_req), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 The block SHALL have parameter NUM_REGIONS, default 8, meaning the number of ROM regions (1..32).
REQ-002 The block SHALL have parameter WORD_BYTES, default 2, meaning the bytes per target write word (1, 2 or 4).
REQ-003 The block SHALL have parameter REGION_END, default rom_loader_pkg::DEFAULT_REGION_END, meaning an array of NUM_REGIONS ascending exclusive end addresses (25 bits each).
REQ-004 The block SHALL have ports, one per line as name direction width meaning:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
ioctl_download  in  1  download window active
ioctl_wr  in  1  byte strobe, one cycle
ioctl_addr  in  25  byte address of the download stream
ioctl_dout  in  8  download byte
ioctl_wait  out  1  stall request to the download source
wr_req  out  1  write request to the target memory
wr_ack  in  1  write accepted
wr_cs  out  NUM_REGIONS  one-hot region select
wr_addr  out  24  word address within the region
wr_data  out  8*WORD_BYTES  packed word, little-endian
wr_be  out  WORD_BYTES  byte enables
load_done  out  1  download completed and all writes acked
bad_addr  out  1  sticky flag: a byte fell outside all regions
checksum  out  16  byte sum (see Configuration)

Function
REQ-005 Region decode SHALL select the lowest index i with ioctl_addr < REGION_END[i]; region start = REGION_END[i-1], or 0 for i=0.
REQ-006 A byte at or above REGION_END[NUM_REGIONS-1] SHALL be dropped and SHALL set bad_addr.
REQ-007 For offset = addr - start: lane = offset mod WORD_BYTES and word address = offset / WORD_BYTES; the byte SHALL be placed in its lane and set that wr_be bit.
REQ-008 States SHALL be IDLE, COLLECT, WRITE and DRAIN.
- IDLE -> COLLECT on rising ioctl_download.
- COLLECT -> WRITE on a flush condition.
- WRITE -> COLLECT on wr_ack.
- COLLECT -> DRAIN on falling ioctl_download.
- DRAIN -> IDLE after the final ack.
REQ-009 Flush conditions SHALL be:
- the byte fills lane WORD_BYTES-1;
- the next accepted byte has a different region or word address (the partial word is flushed first);
- ioctl_download falls while a partial word is pending.
REQ-010 wr_req SHALL assert the cycle after the flushing byte's ioctl_wr.
REQ-011 wr_cs, wr_addr, wr_data and wr_be SHALL hold stable while wr_req is high.
REQ-012 wr_req SHALL deassert the cycle after wr_ack is sampled high.
REQ-013 wr_ack SHALL be ignored while wr_req is low.
REQ-014 A one-byte holding register SHALL capture a byte arriving while in WRITE.
REQ-015 ioctl_wait SHALL be high while wr_req is high or the holding register is valid.
REQ-016 A byte arriving when the holding register is full SHALL be dropped and SHALL set bad_addr.
REQ-017 The held byte SHALL be consumed in the first COLLECT cycle.
REQ-018 When WORD_BYTES=1, every accepted byte SHALL flush immediately with wr_be=1.
REQ-019 load_done SHALL set on DRAIN -> IDLE.
REQ-020 A rising ioctl_download from any state SHALL clear load_done, bad_addr, checksum, the accumulator and the holding register, discarding any unacked word.
REQ-021 ioctl_wr SHALL be ignored while ioctl_download is low.

Reset
REQ-022 Asserting reset_n low SHALL force state IDLE and clear the accumulator and holding register.
REQ-023 During reset, all outputs SHALL be 0: wr_req, ioctl_wait, wr_cs, wr_addr, wr_data, wr_be, load_done, bad_addr and checksum.
REQ-024 Reset mid-WRITE SHALL drop the pending word without waiting for wr_ack.

Configuration
REQ-025 With ROM_LOADER_CHECKSUM_EN defined, checksum SHALL be the modulo-2^16 sum of all in-range accepted bytes since the last rising ioctl_download.
REQ-026 Without ROM_LOADER_CHECKSUM_EN, checksum SHALL be tied to 0 and the adder omitted.

Structure
REQ-027 Package rom_loader_pkg SHALL hold the state enum, MAX_REGIONS=32 and DEFAULT_REGION_END, which is the 8-region table 'h10000, 'h20000, 'h30000, 'h40000, 'h60000, 'h80000, 'hC0000, 'hE0000.
REQ-028 Region decode SHALL be a separate sub-module, rom_region_decode, that is combinational and outputs the one-hot select, start address and out-of-range flag.

Verification
REQ-029 The bench SHALL cover: WORD_BYTES=2, bytes 11,22 at 'h00000/'h00001 -> one write with wr_cs=0x01, wr_addr=0, wr_data=16'h2211, wr_be=2'b11.
REQ-030 The bench SHALL cover: a single byte AB at 'h1FFFF followed by the next byte at 'h20000 -> write wr_cs=0x02, wr_addr='h7FFF, wr_data[15:8]=AB, wr_be=2'b10, then region 2 begins at wr_addr 0.
REQ-031 The bench SHALL cover: wr_ack held low 10 cycles with a byte arriving in WRITE -> ioctl_wait is high, the byte is held and nothing is lost; a second byte arriving in that window sets bad_addr.
REQ-032 The bench SHALL cover: a byte at 'hE0000 -> no write and bad_addr=1; a new rising ioctl_download clears it.
REQ-033 The bench SHALL cover: 3 bytes then ioctl_download falls -> a partial write with wr_be=2'b01, then load_done=1 one cycle after the final ack.
REQ-034 The bench SHALL cover: ROM_LOADER_CHECKSUM_EN with bytes FF,FF,02 -> checksum=16'h0200; reset_n low mid-WRITE -> all outputs 0 asynchronously.
